// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter that shares one single-port RAM between NUM_REQ requesters.
// It grants one transaction at a time and routes read data back to the requester that issued it.
module ram_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          ram_en,
    output logic                          ram_we,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_din,
    input  logic [DATA_WIDTH-1:0]         ram_dout,
    output logic                          busy
);

    localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNTW = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                 state_q, state_d;
    logic [IDW-1:0]         ptr_q, ptr_d;
    logic [IDW-1:0]         id_q, id_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;

    logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                   ram_en_q, ram_en_d;
    logic                   ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0]  ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]  ram_din_q, ram_din_d;
    logic                   busy_q, busy_d;

    logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  wdata_arr [NUM_REQ];
    logic                   grant_found;
    logic [IDW-1:0]         grant_id;
    logic [IDW-1:0]         cand;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Search starts just after the last winner, so the last winner has the lowest priority.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDW'((int'(ptr_q) + i) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    state_d = ISSUE;
                    ptr_d   = grant_id;
                    id_d    = grant_id;
                    we_d    = req_we[grant_id];
                    addr_d  = addr_arr[grant_id];
                    wdata_d = wdata_arr[grant_id];
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNTW'(RD_LATENCY);
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNTW'(1)) begin
                    state_d     = RESP;
                    rsp_rdata_d = ram_dout;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that, once registered, they line up with it.
    always_comb begin
        req_ready_d = '0;
        rsp_valid_d = '0;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = '0;
        ram_din_d   = '0;
        busy_d      = (state_d != IDLE);
        if (state_d == ISSUE) begin
            req_ready_d = NUM_REQ'(1) << id_d;
            ram_en_d    = 1'b1;
            ram_we_d    = we_d;
            ram_addr_d  = addr_d;
            ram_din_d   = wdata_d;
        end
        if (state_d == RESP) begin
            rsp_valid_d = NUM_REQ'(1) << id_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from the same old values.
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= IDW'(NUM_REQ - 1);
            id_q        <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter: behavioural RAM, reference memory and a response scoreboard.
module tb_ram_rr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int AW         = 8;
    localparam int DW         = 8;
    localparam int RD_LATENCY = 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid, req_we, req_ready, rsp_valid;
    logic [NUM_REQ*AW-1:0]  req_addr;
    logic [NUM_REQ*DW-1:0]  req_wdata;
    logic [DW-1:0]          rsp_rdata, ram_din, ram_dout;
    logic [AW-1:0]          ram_addr;
    logic                   ram_en, ram_we, busy;

    always #5 clk = ~clk;

    ram_rr_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .busy(busy)
    );

    // Behavioural single-port RAM with RD_LATENCY read pipeline.
    logic [DW-1:0] ram_mem [256];
    logic [DW-1:0] rd_pipe [RD_LATENCY];
    always @(posedge clk) begin
        if (ram_en && ram_we) ram_mem[ram_addr] <= ram_din;
        if (ram_en && !ram_we) rd_pipe[0] <= ram_mem[ram_addr];
        for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_dout = rd_pipe[RD_LATENCY-1];

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } exp_t;
    exp_t          sb_q[$];
    logic [DW-1:0] ref_mem [256];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every response must match an outstanding read of the same requester.
    int hit;
    always @(negedge clk) begin
        if (!rst && rsp_valid != '0) begin
            hit = -1;
            foreach (sb_q[k]) if (hit < 0 && rsp_valid == 4'(1 << sb_q[k].id)) hit = k;
            check("rsp_expected", 64'(hit >= 0), 64'd1);
            if (hit >= 0) begin
                check("rsp_rdata", 64'(rsp_rdata), 64'(sb_q[hit].data));
                sb_q.delete(hit);
            end
        end
    end

    always @(negedge clk) begin
        check("ready_onehot", 64'($onehot0(req_ready)), 64'd1);
        check("rsp_onehot", 64'($onehot0(rsp_valid)), 64'd1);
        check("ram_en_only_busy", 64'(ram_en && !busy), 64'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int id, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[id]           = v;
        req_we[id]              = we;
        req_addr[id*AW +: AW]   = a;
        req_wdata[id*DW +: DW]  = d;
    endtask

    task automatic wait_ready(output int at);
        at = -1;
        for (int n = 0; n < 20 && at < 0; n++) begin
            @(negedge clk);
            if (req_ready != '0) at = cyc_cnt;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_write(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int at;
        set_req(id, 1'b1, 1'b1, a, d);
        wait_ready(at);
        check("wr_ready", 64'(req_ready), 64'(1 << id));
        check("wr_ram", 64'({ram_en, ram_we, ram_addr, ram_din}), 64'({2'b11, a, d}));
        ref_mem[a] = d;
        set_req(id, 1'b0, 1'b0, a, d);
        @(negedge clk);
    endtask

    task automatic do_read(input int id, input logic [AW-1:0] a);
        int at;
        set_req(id, 1'b1, 1'b0, a, '0);
        sb_q.push_back('{id: id, data: ref_mem[a]});
        wait_ready(at);
        check("rd_ready", 64'(req_ready), 64'(1 << id));
        set_req(id, 1'b0, 1'b0, a, '0);
        for (int n = 0; n < 20 && rsp_valid == '0; n++) @(negedge clk);
        check("rd_rsp", 64'(rsp_valid), 64'(1 << id));
    endtask

    initial begin
        int at, prev, eid;
        rst = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;

        // 1: reset with random requests, then one quiet cycle after release
        for (int n = 0; n < 2; n++) begin
            req_valid = 4'($urandom); req_we = 4'($urandom);
            req_addr = 32'($urandom); req_wdata = 32'($urandom);
            @(negedge clk);
            check("rst_outputs", 64'({req_ready, rsp_valid, rsp_rdata, ram_en, ram_we, ram_addr, ram_din, busy}), 64'd0);
        end
        rst = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("post_rst_outputs", 64'({req_ready, rsp_valid, ram_en, busy}), 64'd0);

        // 2: write then read back through requester 0 with exact cycle timing
        set_req(0, 1'b1, 1'b1, 8'h10, 8'hA5);
        @(negedge clk);
        check("t2_wr_ram", 64'({ram_en, ram_we, ram_addr, ram_din}), 64'({2'b11, 8'h10, 8'hA5}));
        check("t2_wr_ready", 64'(req_ready), 64'b0001);
        ref_mem[8'h10] = 8'hA5;
        set_req(0, 1'b0, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        check("t2_wr_done", 64'({busy, ram_en, req_ready}), 64'd0);
        set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
        sb_q.push_back('{id: 0, data: ref_mem[8'h10]});
        @(negedge clk);
        check("t2_rd_issue", 64'({ram_en, ram_we, ram_addr, req_ready}), 64'({2'b10, 8'h10, 4'b0001}));
        set_req(0, 1'b0, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        check("t2_rd_wait", 64'({busy, ram_en, rsp_valid}), 64'({1'b1, 1'b0, 4'b0000}));
        @(negedge clk);
        check("t2_rd_rsp", 64'({rsp_valid, rsp_rdata}), 64'({4'b0001, 8'hA5}));
        @(negedge clk);
        check("t2_rdata_hold", 64'({busy, rsp_valid, rsp_rdata}), 64'({1'b0, 4'b0000, 8'hA5}));

        // 3: all four write continuously -> 0,1,2,3,0 every 2 cycles
        do_reset(1);
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b1, 8'(8'h20 + i), 8'(8'h50 + i));
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            eid = k % NUM_REQ;
            wait_ready(at);
            check("t3_order", 64'(req_ready), 64'(1 << eid));
            check("t3_ram", 64'({ram_we, ram_addr, ram_din}), 64'({1'b1, 8'(8'h20 + eid), 8'(8'h50 + eid)}));
            if (k > 0) check("t3_gap", 64'(at - prev), 64'd2);
            prev = at;
            ref_mem[8'(8'h20 + eid)] = 8'(8'h50 + eid);
            if (k == 4) req_valid = '0;
        end
        @(negedge clk);
        check("t3_idle", 64'(busy), 64'd0);

        // 4: requesters 0 and 2 read continuously -> 0,2,0,2 every 4 cycles
        do_reset(1);
        set_req(0, 1'b1, 1'b0, 8'h20, 8'h00);
        set_req(2, 1'b1, 1'b0, 8'h22, 8'h00);
        for (int k = 0; k < 4; k++) begin
            eid = (k % 2) * 2;
            wait_ready(at);
            check("t4_order", 64'(req_ready), 64'(1 << eid));
            sb_q.push_back('{id: eid, data: ref_mem[8'(8'h20 + eid)]});
            if (k > 0) check("t4_gap", 64'(at - prev), 64'(3 + RD_LATENCY));
            prev = at;
            if (k == 3) req_valid = '0;
        end
        for (int n = 0; n < 20 && sb_q.size() != 0; n++) @(negedge clk);
        check("t4_drain", 64'(sb_q.size()), 64'd0);
        @(negedge clk);

        // 5: reset during WAIT of a read by requester 1 drops it
        set_req(1, 1'b1, 1'b0, 8'h21, 8'h00);
        wait_ready(at);
        check("t5_ready", 64'(req_ready), 64'b0010);
        set_req(1, 1'b0, 1'b0, 8'h21, 8'h00);
        @(negedge clk);
        check("t5_in_wait", 64'({busy, ram_en}), 64'b10);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_idle", 64'({busy, rsp_valid, req_ready}), 64'd0);
        rst = 1'b0;
        set_req(0, 1'b1, 1'b1, 8'h30, 8'h11);
        set_req(1, 1'b1, 1'b1, 8'h31, 8'h22);
        wait_ready(at);
        check("t5_first", 64'(req_ready), 64'b0001);
        ref_mem[8'h30] = 8'h11;
        set_req(0, 1'b0, 1'b0, 8'h30, 8'h11);
        wait_ready(at);
        check("t5_second", 64'(req_ready), 64'b0010);
        ref_mem[8'h31] = 8'h22;
        set_req(1, 1'b0, 1'b0, 8'h31, 8'h22);
        @(negedge clk);

        // 6: read by 3 followed back-to-back by a write from 1
        do_write(3, 8'h05, 8'h3C);
        set_req(3, 1'b1, 1'b0, 8'h05, 8'h00);
        sb_q.push_back('{id: 3, data: ref_mem[8'h05]});
        @(negedge clk);
        check("t6_rd_ready", 64'(req_ready), 64'b1000);
        set_req(3, 1'b0, 1'b0, 8'h05, 8'h00);
        set_req(1, 1'b1, 1'b1, 8'h40, 8'h77);
        @(negedge clk);
        check("t6_wait", 64'({busy, ram_en, req_ready}), 64'({2'b10, 4'b0000}));
        @(negedge clk);
        check("t6_rsp", 64'({rsp_valid, rsp_rdata}), 64'({4'b1000, 8'h3C}));
        @(negedge clk);
        check("t6_idle_gap", 64'({ram_en, req_ready}), 64'd0);
        @(negedge clk);
        check("t6_wr_issue", 64'({req_ready, ram_en, ram_we, ram_addr, ram_din}),
              64'({4'b0010, 2'b11, 8'h40, 8'h77}));
        ref_mem[8'h40] = 8'h77;
        set_req(1, 1'b0, 1'b0, 8'h40, 8'h77);
        @(negedge clk);
        check("t6_no_rsp", 64'({busy, rsp_valid}), 64'd0);
        do_read(2, 8'h40);
        repeat (2) @(negedge clk);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
